// File: rtl/fifo_flags_if.sv
// Handshake bundle for fifo_flags: push/pop requests and write data in, head word and status flags out.
// The master modport is the client side; the slave modport is the FIFO itself.
interface fifo_flags_if #(
  parameter int WORD_BITS = 8,
  parameter int ADDR_BITS = 4
);
  logic                 i_rd;
  logic                 i_wr;
  logic [WORD_BITS-1:0] i_wdata;
  logic                 i_err_clr;
  logic [WORD_BITS-1:0] o_rdata;
  logic                 o_empty;
  logic                 o_full;
  logic                 o_almost_empty;
  logic                 o_almost_full;
  logic [ADDR_BITS:0]   o_count;
  logic                 o_overflow;
  logic                 o_underflow;

  modport master (
    output i_rd, i_wr, i_wdata, i_err_clr,
    input  o_rdata, o_empty, o_full, o_almost_empty, o_almost_full,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_rd, i_wr, i_wdata, i_err_clr,
    output o_rdata, o_empty, o_full, o_almost_empty, o_almost_full,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_flags.sv
// Single-clock first-word-fall-through FIFO with occupancy count, almost flags and boundary rd/wr rules.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they are tied low.
module fifo_flags #(
  parameter int WORD_BITS     = 8,
  parameter int ADDR_BITS     = 4,
  parameter int AFULL_THRESH  = 2**ADDR_BITS - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input logic          i_clk,
  input logic          i_reset_n,
  fifo_flags_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_BITS;
  localparam int CNT_W = ADDR_BITS + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_THRESH);

  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wptr;
  logic [ADDR_BITS-1:0] rptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic                 full_q;
  logic                 empty_q;
  logic                 wr_ok;
  logic                 rd_ok;

  // Acceptance uses the registered flags, so a pop on empty or a push on full is simply dropped.
  assign wr_ok = bus.i_wr & ~full_q;
  assign rd_ok = bus.i_rd & ~empty_q;

  always_comb begin
    count_next = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + ADDR_BITS'(1);
      end
      if (rd_ok) begin
        rptr <= rptr + ADDR_BITS'(1);
      end
      count   <= count_next;
      full_q  <= (count_next == DEPTH_CNT);
      empty_q <= (count_next == '0);
    end
  end

  // Storage is deliberately left out of reset; stale words are hidden behind o_empty.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && wr_ok) begin
      mem[wptr] <= bus.i_wdata;
    end
  end

  assign bus.o_rdata        = mem[rptr];
  assign bus.o_count        = count;
  assign bus.o_full         = full_q;
  assign bus.o_empty        = empty_q;
  assign bus.o_almost_full  = (count >= AFULL_CNT);
  assign bus.o_almost_empty = (count <= AEMPTY_CNT);

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // A new violation in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.i_wr && full_q) begin
        overflow_q <= 1'b1;
      end else if (bus.i_err_clr) begin
        overflow_q <= 1'b0;
      end
      if (bus.i_rd && empty_q) begin
        underflow_q <= 1'b1;
      end else if (bus.i_err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.o_overflow  = overflow_q;
  assign bus.o_underflow = underflow_q;
`else
  logic unused_err_clr;

  assign unused_err_clr  = bus.i_err_clr;
  assign bus.o_overflow  = 1'b0;
  assign bus.o_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_flags.sv
// Self-checking bench for fifo_flags: directed vector table, boundary sequences and random traffic
// compared against a queue-based reference model.
module tb_fifo_flags;
  localparam int WORD_BITS = 8;
  localparam int ADDR_BITS = 4;
  localparam int DEPTH     = 16;
  localparam int AFULL     = 14;
  localparam int AEMPTY    = 1;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_flags_if #(.WORD_BITS(WORD_BITS), .ADDR_BITS(ADDR_BITS)) bus ();

  fifo_flags #(
    .WORD_BITS(WORD_BITS), .ADDR_BITS(ADDR_BITS),
    .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .bus(bus)
  );

  logic [7:0] modelQ[$];
  bit modelOvf;
  bit modelUnf;
  int checkCount = 0;
  int passCount = 0;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
    logic       clr;
    int         expCount;
    logic       expEmpty;
    logic       expHead;
    logic [7:0] headVal;
    logic       expUnf;
  } vec_t;

  vec_t vecs[9];

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference behaviour: a plain queue with capacity DEPTH, decisions made on the pre-edge occupancy.
  task automatic modelStep(input logic rd, input logic wr, input logic [7:0] wdata,
                           input logic clr, input logic rstn);
    int sz;
    if (!rstn) begin
      modelQ.delete();
      modelOvf = 0;
      modelUnf = 0;
      return;
    end
    sz = modelQ.size();
    if (wr && sz == DEPTH) modelOvf = 1;
    else if (clr) modelOvf = 0;
    if (rd && sz == 0) modelUnf = 1;
    else if (clr) modelUnf = 0;
    if (rd && sz > 0) void'(modelQ.pop_front());
    if (wr && sz < DEPTH) modelQ.push_back(wdata);
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] wdata,
                               input logic clr, input logic rstn);
    bus.i_rd      = rd;
    bus.i_wr      = wr;
    bus.i_wdata   = wdata;
    bus.i_err_clr = clr;
    reset_n       = rstn;
    @(posedge clk);
    #1;
    modelStep(rd, wr, wdata, clr, rstn);
  endtask

  task automatic checkOutput(input string tag);
    int sz;
    sz = modelQ.size();
    compareVal({tag, ".count"}, 32'(bus.o_count), 32'(sz));
    compareVal({tag, ".empty"}, 32'(bus.o_empty), 32'(sz == 0));
    compareVal({tag, ".full"}, 32'(bus.o_full), 32'(sz == DEPTH));
    compareVal({tag, ".aempty"}, 32'(bus.o_almost_empty), 32'(sz <= AEMPTY));
    compareVal({tag, ".afull"}, 32'(bus.o_almost_full), 32'(sz >= AFULL));
    compareVal({tag, ".ovf"}, 32'(bus.o_overflow), 32'(ERR_EN & modelOvf));
    compareVal({tag, ".unf"}, 32'(bus.o_underflow), 32'(ERR_EN & modelUnf));
    if (sz > 0) compareVal({tag, ".rdata"}, 32'(bus.o_rdata), 32'(modelQ[0]));
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 1);
  endtask

  initial begin
    bus.i_rd = 0; bus.i_wr = 0; bus.i_wdata = '0; bus.i_err_clr = 0;
    // rd, wr, wdata, clr, count, empty, checkHead, head, unf
    vecs[0] = '{1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1};
    vecs[1] = '{1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1};
    vecs[2] = '{1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1};
    vecs[3] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0};
    vecs[4] = '{1, 1, 8'h55, 0, 1, 0, 1, 8'h55, 1};
    vecs[5] = '{0, 1, 8'h11, 1, 2, 0, 1, 8'h55, 0};
    vecs[6] = '{1, 0, 8'h00, 0, 1, 0, 1, 8'h11, 0};
    vecs[7] = '{1, 1, 8'h22, 0, 1, 0, 1, 8'h22, 0};
    vecs[8] = '{1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0};

    applyStimulus(1, 1, 8'hEE, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    compareVal("rst.count", 32'(bus.o_count), 0);
    compareVal("rst.empty", 32'(bus.o_empty), 1);
    compareVal("rst.full", 32'(bus.o_full), 0);
    compareVal("rst.aempty", 32'(bus.o_almost_empty), 1);
    compareVal("rst.afull", 32'(bus.o_almost_full), 0);
    compareVal("rst.ovf", 32'(bus.o_overflow), 0);
    compareVal("rst.unf", 32'(bus.o_underflow), 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].clr, 1);
      compareVal($sformatf("vec%0d.count", i), 32'(bus.o_count), 32'(vecs[i].expCount));
      compareVal($sformatf("vec%0d.empty", i), 32'(bus.o_empty), 32'(vecs[i].expEmpty));
      compareVal($sformatf("vec%0d.unf", i), 32'(bus.o_underflow), 32'(ERR_EN & vecs[i].expUnf));
      if (vecs[i].expHead)
        compareVal($sformatf("vec%0d.head", i), 32'(bus.o_rdata), 32'(vecs[i].headVal));
      checkOutput($sformatf("vec%0d", i));
    end

    // Fill, overflow attempt, drain in order
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 1, 8'(i), 0, 1);
      compareVal($sformatf("fill%0d.aempty", i), 32'(bus.o_almost_empty), 32'(i + 1 <= 1));
      compareVal($sformatf("fill%0d.afull", i), 32'(bus.o_almost_full), 32'(i + 1 >= 14));
      checkOutput("fill");
    end
    compareVal("fill.count16", 32'(bus.o_count), 16);
    compareVal("fill.full", 32'(bus.o_full), 1);
    applyStimulus(0, 1, 8'hAA, 0, 1);
    compareVal("fill.ovf", 32'(bus.o_overflow), 32'(ERR_EN));
    compareVal("fill.count_hold", 32'(bus.o_count), 16);
    for (int i = 0; i < DEPTH; i++) begin
      compareVal($sformatf("drain%0d.data", i), 32'(bus.o_rdata), 32'(i));
      applyStimulus(1, 0, 8'h00, 0, 1);
      checkOutput("drain");
    end
    compareVal("drain.empty", 32'(bus.o_empty), 1);

    // Simultaneous rd+wr while full: push dropped, pop accepted
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 8'h80 + 8'(i), 0, 1);
    applyStimulus(1, 1, 8'h66, 0, 1);
    compareVal("fullrw.count", 32'(bus.o_count), 15);
    compareVal("fullrw.head", 32'(bus.o_rdata), 32'h81);
    compareVal("fullrw.ovf", 32'(bus.o_overflow), 32'(ERR_EN));
    for (int i = 1; i < DEPTH; i++) begin
      compareVal($sformatf("fullrw.drain%0d", i), 32'(bus.o_rdata), 32'h80 + 32'(i));
      applyStimulus(1, 0, 8'h00, 0, 1);
    end
    compareVal("fullrw.empty", 32'(bus.o_empty), 1);

    // Streaming across pointer wrap at constant occupancy
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'(i), 0, 1);
    for (int i = 0; i < 40; i++) begin
      compareVal($sformatf("wrap%0d.head", i), 32'(bus.o_rdata), 32'(i));
      applyStimulus(1, 1, 8'(i + 8), 0, 1);
      compareVal($sformatf("wrap%0d.count", i), 32'(bus.o_count), 8);
      compareVal($sformatf("wrap%0d.flags", i), 32'({bus.o_empty, bus.o_full}), 0);
    end

    // Reset mid-operation, then error clear priority
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'h40 + 8'(i), 0, 1);
    applyStimulus(1, 1, 8'h99, 0, 0);
    compareVal("midrst.count", 32'(bus.o_count), 0);
    compareVal("midrst.empty", 32'(bus.o_empty), 1);
    applyStimulus(0, 1, 8'h33, 0, 1);
    compareVal("midrst.head", 32'(bus.o_rdata), 32'h33);
    for (int i = 1; i < DEPTH; i++) applyStimulus(0, 1, 8'(i), 0, 1);
    applyStimulus(0, 1, 8'hAA, 0, 1);
    applyStimulus(0, 1, 8'hAB, 1, 1);
    compareVal("errclr.setwins", 32'(bus.o_overflow), 32'(ERR_EN));
    applyStimulus(0, 0, 8'h00, 1, 1);
    compareVal("errclr.cleared", 32'(bus.o_overflow), 0);
    checkOutput("errclr");

    // Random traffic with phases biased towards full and towards empty
    doReset();
    for (int i = 0; i < 600; i++) begin
      int pWr;
      logic rd, wr, clr, rstn;
      pWr  = ((i / 100) % 2 == 0) ? 75 : 25;
      wr   = ($urandom_range(99) < pWr);
      rd   = ($urandom_range(99) < 100 - pWr);
      clr  = ($urandom_range(99) < 5);
      rstn = ($urandom_range(199) != 0);
      applyStimulus(rd, wr, 8'($urandom), clr, rstn);
      checkOutput("rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
